toysram_rf_subarray: RTL and testbench



---
 rtl/toysram_pkg.sv | 10 +
 rtl/toysram_onehot_chk.sv | 19 +
 rtl/toysram_rf_subarray.sv | 112 +++++++++++
 tb/tb_toysram_rf_subarray.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/toysram_pkg.sv
// Shared constants for the toysram register-file subarray: sticky error flag layout.
package toysram_pkg;

  localparam int unsigned ERR_W    = 4;
  localparam int unsigned ERR_RWL0 = 0;
  localparam int unsigned ERR_RWL1 = 1;
  localparam int unsigned ERR_WWL  = 2;
  localparam int unsigned ERR_WBL  = 3;

endpackage

// File: rtl/toysram_onehot_chk.sv
// Classifies a wordline vector as zero-hot, one-hot or multi-hot.
module toysram_onehot_chk #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] vec,
  output logic         zero_hot,
  output logic         one_hot,
  output logic         multi_hot
);

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  logic [N-1:0] low_cleared;

  assign low_cleared = vec & (vec - N'(1));
  assign zero_hot    = ~|vec;
  assign multi_hot   = |low_cleared;
  assign one_hot     = ~zero_hot & ~multi_hot;

endmodule

// File: rtl/toysram_rf_subarray.sv
// ROWS x BITS register-file subarray: two one-hot read ports, one differential write port.
// Define TOYSRAM_RF_BYPASS_EN to make a read of the row being written return the new data.
module toysram_rf_subarray
  import toysram_pkg::*;
#(
  parameter int unsigned ROWS = 32,
  parameter int unsigned BITS = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROWS-1:0]  rwl0,
  input  logic [ROWS-1:0]  rwl1,
  input  logic [ROWS-1:0]  wwl,
  input  logic [BITS-1:0]  wbl,
  input  logic [BITS-1:0]  wblb,
  output logic [BITS-1:0]  rbl0,
  output logic [BITS-1:0]  rbl1,
  output logic [ERR_W-1:0] err,
  input  logic             err_clr
);

  logic [BITS-1:0]  mem_q [ROWS];
  logic [BITS-1:0]  row_rd [ROWS];
  logic [BITS-1:0]  rbl0_d, rbl0_q, rbl1_d, rbl1_q;
  logic [ERR_W-1:0] err_set, err_d, err_q;

  logic rwl0_zero, rwl0_one, rwl0_multi;
  logic rwl1_zero, rwl1_one, rwl1_multi;
  logic wwl_zero, wwl_one, wwl_multi;
  logic bl_ok, wr_ok;
  logic unused_hot;

  toysram_onehot_chk #(.N(ROWS)) u_chk_rwl0 (
    .vec       (rwl0),
    .zero_hot  (rwl0_zero),
    .one_hot   (rwl0_one),
    .multi_hot (rwl0_multi)
  );

  toysram_onehot_chk #(.N(ROWS)) u_chk_rwl1 (
    .vec       (rwl1),
    .zero_hot  (rwl1_zero),
    .one_hot   (rwl1_one),
    .multi_hot (rwl1_multi)
  );

  toysram_onehot_chk #(.N(ROWS)) u_chk_wwl (
    .vec       (wwl),
    .zero_hot  (wwl_zero),
    .one_hot   (wwl_one),
    .multi_hot (wwl_multi)
  );

  assign unused_hot = ^{rwl0_zero, rwl0_one, rwl1_zero, rwl1_one};

  assign bl_ok = &(wbl ^ wblb);
  assign wr_ok = wwl_one & bl_ok;

  for (genvar r = 0; r < ROWS; r++) begin : g_row_rd
`ifdef TOYSRAM_RF_BYPASS_EN
    assign row_rd[r] = (wr_ok && wwl[r]) ? wbl : mem_q[r];
`else
    assign row_rd[r] = mem_q[r];
`endif
  end

  // Unselected rows are gated out entirely, so their contents never reach the bitlines.
  always_comb begin
    rbl0_d = '0;
    rbl1_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rwl0[r]) rbl0_d = rbl0_d | row_rd[r];
      if (rwl1[r]) rbl1_d = rbl1_d | row_rd[r];
    end
  end

  always_comb begin
    err_set           = '0;
    err_set[ERR_RWL0] = rwl0_multi;
    err_set[ERR_RWL1] = rwl1_multi;
    err_set[ERR_WWL]  = wwl_multi;
    err_set[ERR_WBL]  = ~wwl_zero & ~bl_ok;
    err_d             = (err_clr ? '0 : err_q) | err_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (wr_ok && wwl[r]) mem_q[r] <= wbl;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbl0_q <= '0;
      rbl1_q <= '0;
      err_q  <= '0;
    end else begin
      rbl0_q <= rbl0_d;
      rbl1_q <= rbl1_d;
      err_q  <= err_d;
    end
  end

  assign rbl0 = rbl0_q;
  assign rbl1 = rbl1_q;
  assign err  = err_q;

endmodule

// File: tb/tb_toysram_rf_subarray.sv
// Self-checking bench for toysram_rf_subarray (32x12) against an array-based reference model.
module tb_toysram_rf_subarray;

  localparam int unsigned ROWS = 32;
  localparam int unsigned BITS = 12;
`ifdef TOYSRAM_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [ROWS-1:0] rwl0, rwl1, wwl;
  logic [BITS-1:0] wbl, wblb, rbl0, rbl1;
  logic [3:0]      err;
  logic            err_clr;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [BITS-1:0] mmem [ROWS];
  logic [3:0]      merr;

  toysram_rf_subarray #(.ROWS(ROWS), .BITS(BITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .rwl0    (rwl0),
    .rwl1    (rwl1),
    .wwl     (wwl),
    .wbl     (wbl),
    .wblb    (wblb),
    .rbl0    (rbl0),
    .rbl1    (rbl1),
    .err     (err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROWS-1:0] oh(input int i);
    logic [ROWS-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [BITS-1:0] model_rd(input logic [ROWS-1:0] sel, input bit wr_ok,
                                               input logic [ROWS-1:0] wsel,
                                               input logic [BITS-1:0] wd);
    logic [BITS-1:0] r;
    r = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (sel[i]) r = r | ((BYP && wr_ok && wsel[i]) ? wd : mmem[i]);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ROWS; i++) mmem[i] = '0;
    merr = '0;
  endtask

  // Drive one cycle of stimulus, predict the outcome, then compare after the edge.
  task automatic step(input logic [ROWS-1:0] r0, input logic [ROWS-1:0] r1,
                      input logic [ROWS-1:0] w, input logic [BITS-1:0] d,
                      input logic [BITS-1:0] db, input logic clr, input string tag);
    bit              wr_ok;
    logic [BITS-1:0] e0, e1;
    logic [3:0]      eset;
    rwl0 = r0; rwl1 = r1; wwl = w; wbl = d; wblb = db; err_clr = clr;
    wr_ok = ($countones(w) == 1) && ((d ^ db) == {BITS{1'b1}});
    e0 = model_rd(r0, wr_ok, w, d);
    e1 = model_rd(r1, wr_ok, w, d);
    eset[0] = $countones(r0) > 1;
    eset[1] = $countones(r1) > 1;
    eset[2] = $countones(w) > 1;
    eset[3] = (w != '0) && ((d ^ db) != {BITS{1'b1}});
    merr = (clr ? 4'b0 : merr) | eset;
    if (wr_ok) begin
      for (int i = 0; i < ROWS; i++) if (w[i]) mmem[i] = d;
    end
    @(posedge clk);
    #1;
    check({tag, ".rbl0"}, 64'(rbl0), 64'(e0));
    check({tag, ".rbl1"}, 64'(rbl1), 64'(e1));
    check({tag, ".err"}, 64'(err), 64'(merr));
  endtask

  task automatic wr(input int row, input logic [BITS-1:0] d, input string tag);
    step('0, '0, oh(row), d, ~d, 1'b0, tag);
  endtask

  initial begin
    logic [ROWS-1:0] r0, r1, w;
    logic [BITS-1:0] d, db;
    reset = 1'b1;
    rwl0 = '0; rwl1 = '0; wwl = '0; wbl = '0; wblb = '1; err_clr = 1'b0;
    model_reset();
    #12;
    check("reset.rbl0", 64'(rbl0), 64'h0);
    check("reset.rbl1", 64'(rbl1), 64'h0);
    check("reset.err", 64'(err), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    step(oh(0), oh(0), '0, '0, '1, 1'b0, "rd_r0");
    step(oh(ROWS - 1), oh(ROWS - 1), '0, '0, '1, 1'b0, "rd_rlast");

    wr(5, 12'hA5A, "wr5");
    step(oh(5), oh(31), '0, '0, '1, 1'b0, "rd5");
    check("rd5.literal", 64'(rbl0), 64'hA5A);

    wr(3, 12'h00F, "wr3");
    wr(4, 12'h0F0, "wr4");
    step(oh(3) | oh(4), '0, '0, '0, '1, 1'b0, "rd_multi");
    check("rd_multi.literal", 64'(rbl0), 64'h0FF);
    check("rd_multi.err_lit", 64'(err), 64'h1);
    step('0, '0, '0, '0, '1, 1'b1, "err_clr");

    step('0, '0, oh(1) | oh(2), 12'hFFF, 12'h000, 1'b0, "wwl_multi");
    step(oh(1), oh(2), '0, '0, '1, 1'b1, "rd12");
    step('0, '0, oh(7), 12'h000, 12'h000, 1'b0, "wbl_bad");
    step(oh(7), '0, '0, '0, '1, 1'b1, "rd7");

    wr(9, 12'h111, "wr9");
    step('0, oh(9), oh(9), 12'h222, 12'hDDD, 1'b0, "collide9");
    check("collide9.literal", 64'(rbl1), BYP ? 64'h222 : 64'h111);
    step('0, oh(9), '0, '0, '1, 1'b0, "rd9");
    check("rd9.literal", 64'(rbl1), 64'h222);

    // Set outputs and err non-zero, then reset mid-cycle during a write to row 10.
    step(oh(5) | oh(3), oh(5), '0, '0, '1, 1'b0, "pre_rst");
    rwl0 = '0; rwl1 = '0; wwl = oh(10); wbl = 12'h3C3; wblb = 12'hC3C;
    #3;
    reset = 1'b1;
    #1;
    check("async_rst.rbl0", 64'(rbl0), 64'h0);
    check("async_rst.rbl1", 64'(rbl1), 64'h0);
    check("async_rst.err", 64'(err), 64'h0);
    model_reset();
    @(posedge clk); #1;
    wwl = '0;
    reset = 1'b0;
    step(oh(10), oh(10), '0, '0, '1, 1'b0, "rd10");
    step(oh(5), oh(9), '0, '0, '1, 1'b0, "rd_after_rst");

    for (int n = 0; n < 250; n++) begin
      int k;
      k = $urandom_range(0, 9);
      r0 = (k < 2) ? '0 : (k < 9) ? oh($urandom_range(0, ROWS - 1))
                                  : oh($urandom_range(0, ROWS - 1)) | oh($urandom_range(0, ROWS - 1));
      k = $urandom_range(0, 9);
      r1 = (k < 2) ? '0 : (k < 9) ? oh($urandom_range(0, ROWS - 1))
                                  : oh($urandom_range(0, ROWS - 1)) | oh($urandom_range(0, ROWS - 1));
      k = $urandom_range(0, 9);
      w = (k < 3) ? '0 : (k < 9) ? oh($urandom_range(0, ROWS - 1))
                                 : oh($urandom_range(0, ROWS - 1)) | oh($urandom_range(0, ROWS - 1));
      d = BITS'($urandom);
      db = ~d;
      if ($urandom_range(0, 9) == 0) db[$urandom_range(0, BITS - 1)] ^= 1'b1;
      step(r0, r1, w, d, db, 1'($urandom_range(0, 3) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
